fe_arbiter: RTL and testbench
=============================

Name: fe_arbiter

Overview:
- Round-robin scheduler sharing the single forwarding-engine (FE) input between the N_PORTS MAC receive paths.
- Each MAC presents a packet as 256-bit beats plus a 12-bit byte length on its arb_valid / arb_mac_rdy handshake.
- The arbiter grants one MAC at a time and steers that MAC's whole packet to the FE. It then advances the round-robin pointer.
- Sits between the mac instances and the FE inside switch; a per-port enable mask provides configuration.

Parameters:
N_PORTS, 8, number of MAC requesters
DATA_W, 256, beat width in bits (32 bytes)
LEN_W, 12, packet length width in bytes
MAX_PKT_LEN, 1522, lengths above this set len_err

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
arb_valid  in  N_PORTS  per-MAC beat valid
arb_mac_rdy  out  N_PORTS  per-MAC beat accept
mac_fe_data  in  N_PORTS*DATA_W  per-MAC beat data, port i at [i*DATA_W +: DATA_W]
mac_fe_pkt_len  in  N_PORTS*LEN_W  per-MAC packet byte length, valid while arb_valid is high
port_en  in  N_PORTS  per-port grant enable
fe_valid  out  1  beat valid to FE
fe_ready  in  1  FE accepts beat
fe_data  out  DATA_W  granted beat data
fe_sop  out  1  first beat of packet
fe_eop  out  1  last beat of packet
fe_port  out  3  granted port index
fe_pkt_len  out  LEN_W  latched packet length
busy  out  1  state is XFER
pkt_cnt  out  32  packets forwarded, wraps at 2^32
len_err  out  1  sticky length error
len_err_clr  in  1  clears len_err

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE, rr_ptr=0, grant=0, beats_left=0, first=0.
  - pkt_cnt=0, len_err=0.
  - All outputs 0: arb_mac_rdy, fe_valid, fe_sop, fe_eop, fe_port, fe_pkt_len, busy.
  - A reset mid-packet abandons the packet; no FE-side flush.
- Requests: req = arb_valid & port_en.
- IDLE, req nonzero:
  - Pick the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap mod N_PORTS; store it in grant.
  - Latch L = mac_fe_pkt_len[grant].
  - beats_left = (L+31)>>5, forced to 1 when L==0 (8-bit counter, max 128).
  - Set first=1 and go to XFER.
  - The IDLE cycle transfers nothing: grant-to-first-beat latency is 1 cycle.
- IDLE, req zero: stay in IDLE.
- XFER outputs:
  - fe_valid = arb_valid[grant]; fe_data = mac_fe_data[grant].
  - arb_mac_rdy[grant] = fe_ready; all other arb_mac_rdy bits are 0.
  - fe_sop = fe_valid & first; fe_eop = fe_valid & (beats_left==1).
  - fe_port = grant; fe_pkt_len = latched L; busy=1.
  - These outputs are combinational from arb_valid / fe_ready; there is no extra pipeline stage.
- Beat transfer: occurs when fe_valid & fe_ready. On each transfer, beats_left decrements and first clears.
- Transfer with beats_left==1:
  - pkt_cnt increments.
  - rr_ptr = (grant+1) mod N_PORTS.
  - Go to IDLE; there is always one bubble cycle between packets.
- arb_valid[grant] low in XFER: stall, no timeout.
- Changes to mac_fe_pkt_len after the latch are ignored.
- port_en[grant] cleared mid-packet: the packet still completes. The mask only affects the IDLE pick.
- Length error: L > MAX_PKT_LEN at latch sets len_err. The packet is still forwarded in full (ceil(L/32) beats).
- len_err_clr together with a new error in the same cycle: the set wins.
- rr_ptr wraps from N_PORTS-1 to 0.
- All requests enabled and valid: each port is served once per N_PORTS packets.

Decomposition:
- switch_pkg holds the constants N_PORTS, DATA_W, LEN_W, BYTES_PER_BEAT=32 and MAX_PKT_LEN.
- switch_pkg also holds typedef enum logic {IDLE, XFER} arb_state_t, and typedefs beat_t (DATA_W) and pkt_len_t (LEN_W).
- Sub-module rr_pick: combinational rotate-priority picker with inputs req[N_PORTS] and ptr[3]; outputs gnt_idx[3] and any.

Test Plan:
- Single port: port 3, L=64, fe_ready=1 -> IDLE 1 cycle, then 2 beats. fe_sop on beat 1, fe_eop on beat 2, fe_port=3, fe_pkt_len=64, pkt_cnt=1, rr_ptr=4.
- Round-robin: ports 0, 2, 7 all valid, L=32 each, rr_ptr=0 -> grant order 0, 2, 7, then 0. Each packet is 1 beat with sop=eop=1, and 2 cycles per packet.
- Wrap and mask: rr_ptr=6, requests on ports 1 and 6, port_en[6]=0 -> port 1 granted; rr_ptr becomes 2.
- Backpressure: port 5, L=100 (4 beats), fe_ready low on cycles 2-3 of XFER -> arb_mac_rdy[5] tracks fe_ready, no beat is lost or duplicated, eop only on the 4th transfer.
- Length edges: L=0 -> 1 beat. L=1523 -> 48 beats and len_err=1; len_err_clr returns it to 0. L=4095 -> 128 beats.
- Reset mid-packet: reset low during beat 2 of 4 -> all outputs 0 immediately. After release the next grant starts at port 0 with fe_sop=1.

Source files
------------

// File: rtl/switch_pkg.sv
// ============================================================================
// Module : switch_pkg
// Brief  : Shared constants and types for the switch forwarding-engine arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package switch_pkg;

    localparam int N_PORTS        = 8;
    localparam int DATA_W         = 256;
    localparam int LEN_W          = 12;
    localparam int BYTES_PER_BEAT = 32;
    localparam int MAX_PKT_LEN    = 1522;
    localparam int PORT_W         = $clog2(N_PORTS);
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
    localparam int BEATS_W        = 8;

    typedef enum logic {IDLE, XFER} arb_state_t;

    typedef logic [DATA_W-1:0] beat_t;
    typedef logic [LEN_W-1:0]  pkt_len_t;

endpackage

`default_nettype wire

// File: rtl/fe_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority picker; first set request at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import switch_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [PORT_W-1:0]  ptr,
    output logic [PORT_W-1:0]  gnt_idx,
    output logic               any
);

    logic [PORT_W:0] w_sum;

    // Scan offsets from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        w_sum   = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (PORT_W + 1)'(k);
            if (w_sum >= (PORT_W + 1)'(N_PORTS)) begin
                w_sum = w_sum - (PORT_W + 1)'(N_PORTS);
            end
            if (req[w_sum[PORT_W-1:0]]) begin
                gnt_idx = w_sum[PORT_W-1:0];
                any     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fe_arbiter.sv
// ============================================================================
// Module : fe_arbiter
// Brief  : Round-robin packet arbiter steering one MAC at a time into the FE.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fe_arbiter
    import switch_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PORTS-1:0]        arb_valid,
    output logic [N_PORTS-1:0]        arb_mac_rdy,
    input  logic [N_PORTS*DATA_W-1:0] mac_fe_data,
    input  logic [N_PORTS*LEN_W-1:0]  mac_fe_pkt_len,
    input  logic [N_PORTS-1:0]        port_en,
    output logic                      fe_valid,
    input  logic                      fe_ready,
    output beat_t                     fe_data,
    output logic                      fe_sop,
    output logic                      fe_eop,
    output logic [PORT_W-1:0]         fe_port,
    output pkt_len_t                  fe_pkt_len,
    output logic                      busy,
    output logic [31:0]               pkt_cnt,
    output logic                      len_err,
    input  logic                      len_err_clr
);

    arb_state_t          r_state;
    logic [PORT_W-1:0]   r_rr_ptr;
    logic [PORT_W-1:0]   r_grant;
    logic [BEATS_W-1:0]  r_beats_left;
    logic                r_first;
    pkt_len_t            r_len;
    logic [31:0]         r_pkt_cnt;
    logic                r_len_err;

    logic [N_PORTS-1:0]  w_req;
    logic [PORT_W-1:0]   w_pick_idx;
    logic                w_pick_any;
    pkt_len_t            w_pick_len;
    logic [LEN_W:0]      w_len_round;
    logic [BEATS_W-1:0]  w_pick_beats;
    logic                w_latch;
    logic                w_len_bad;
    logic                w_busy;
    logic                w_xfer;
    logic                w_last;

    assign w_req = arb_valid & port_en;

    rr_pick u_rr_pick (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    assign w_pick_len   = mac_fe_pkt_len[int'(w_pick_idx)*LEN_W +: LEN_W];
    assign w_len_round  = {1'b0, w_pick_len} + (LEN_W + 1)'(BYTES_PER_BEAT - 1);
    // A zero-length packet still occupies one beat on the FE bus.
    assign w_pick_beats = (w_pick_len == '0) ? BEATS_W'(1)
                                             : BEATS_W'(w_len_round >> BEAT_SHIFT);
    assign w_latch      = (r_state == IDLE) && w_pick_any;
    assign w_len_bad    = (w_pick_len > pkt_len_t'(MAX_PKT_LEN));

    assign w_busy   = (r_state == XFER);
    assign fe_valid = w_busy & arb_valid[r_grant];
    assign w_xfer   = fe_valid & fe_ready;
    assign w_last   = (r_beats_left == BEATS_W'(1));

    assign fe_data    = w_busy ? mac_fe_data[int'(r_grant)*DATA_W +: DATA_W] : '0;
    assign fe_sop     = fe_valid & r_first;
    assign fe_eop     = fe_valid & w_last;
    assign fe_port    = w_busy ? r_grant : '0;
    assign fe_pkt_len = w_busy ? r_len : '0;
    assign busy       = w_busy;
    assign pkt_cnt    = r_pkt_cnt;
    assign len_err    = r_len_err;

    always_comb begin
        arb_mac_rdy = '0;
        if (w_busy) begin
            arb_mac_rdy[r_grant] = fe_ready;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_beats_left <= '0;
            r_first      <= 1'b0;
            r_len        <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant      <= w_pick_idx;
                        r_len        <= w_pick_len;
                        r_beats_left <= w_pick_beats;
                        r_first      <= 1'b1;
                        r_state      <= XFER;
                    end
                end
                XFER: begin
                    if (w_xfer) begin
                        r_beats_left <= r_beats_left - BEATS_W'(1);
                        r_first      <= 1'b0;
                        if (w_last) begin
                            r_pkt_cnt <= r_pkt_cnt + 32'd1;
                            r_rr_ptr  <= (r_grant == PORT_W'(N_PORTS - 1)) ? '0
                                                                           : r_grant + PORT_W'(1);
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A fresh error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len_err <= 1'b0;
        end else if (w_latch && w_len_bad) begin
            r_len_err <= 1'b1;
        end else if (len_err_clr) begin
            r_len_err <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fe_arbiter.sv
// ============================================================================
// Module : tb_fe_arbiter
// Brief  : Directed self-checking bench for the FE round-robin arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fe_arbiter;

    logic              clk;
    logic              reset;
    logic [7:0]        arb_valid;
    logic [7:0]        arb_mac_rdy;
    logic [8*256-1:0]  mac_fe_data;
    logic [8*12-1:0]   mac_fe_pkt_len;
    logic [7:0]        port_en;
    logic              fe_valid;
    logic              fe_ready;
    logic [255:0]      fe_data;
    logic              fe_sop;
    logic              fe_eop;
    logic [2:0]        fe_port;
    logic [11:0]       fe_pkt_len;
    logic              busy;
    logic [31:0]       pkt_cnt;
    logic              len_err;
    logic              len_err_clr;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    fe_arbiter u_dut (
        .clk            (clk),
        .reset          (reset),
        .arb_valid      (arb_valid),
        .arb_mac_rdy    (arb_mac_rdy),
        .mac_fe_data    (mac_fe_data),
        .mac_fe_pkt_len (mac_fe_pkt_len),
        .port_en        (port_en),
        .fe_valid       (fe_valid),
        .fe_ready       (fe_ready),
        .fe_data        (fe_data),
        .fe_sop         (fe_sop),
        .fe_eop         (fe_eop),
        .fe_port        (fe_port),
        .fe_pkt_len     (fe_pkt_len),
        .busy           (busy),
        .pkt_cnt        (pkt_cnt),
        .len_err        (len_err),
        .len_err_clr    (len_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int p, input int b);
        logic [255:0] v;
        v = '0;
        v[255:248] = 8'hA0 + 8'(p);
        v[23:16]   = 8'(p);
        v[15:0]    = 16'(b);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_len(input int p, input int l);
        mac_fe_pkt_len[p*12 +: 12] = 12'(l);
    endtask

    // Starts in the idle cycle before the grant; returns in the bubble cycle after the packet.
    task automatic xfer(input int port, input int len, input int beats, input int stall_at);
        logic [7:0] rdy;
        rdy = 8'd1 << port;
        #1;
        check("idle_busy", 256'(busy), 256'(0));
        check("idle_valid", 256'(fe_valid), 256'(0));
        step();
        len_err_clr = 1'b0;
        set_len(port, 12'h5A5);
        for (int b = 0; b < beats; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < 2; s++) begin
                    fe_ready = 1'b0;
                    #1;
                    check("stall_valid", 256'(fe_valid), 256'(1));
                    check("stall_rdy", 256'(arb_mac_rdy), 256'(0));
                    check("stall_sop", 256'(fe_sop), 256'(b == 0));
                    step();
                end
                fe_ready = 1'b1;
            end
            mac_fe_data[port*256 +: 256] = pat(port, b);
            #1;
            check("valid", 256'(fe_valid), 256'(1));
            check("port", 256'(fe_port), 256'(port));
            check("pkt_len", 256'(fe_pkt_len), 256'(len));
            check("sop", 256'(fe_sop), 256'(b == 0));
            check("eop", 256'(fe_eop), 256'(b == beats - 1));
            check("data", fe_data, pat(port, b));
            check("mac_rdy", 256'(arb_mac_rdy), 256'(rdy));
            step();
        end
        exp_cnt++;
        set_len(port, len);
        check("pkt_cnt", 256'(pkt_cnt), 256'(exp_cnt));
    endtask

    initial begin
        reset          = 1'b0;
        arb_valid      = '0;
        port_en        = 8'hFF;
        fe_ready       = 1'b1;
        len_err_clr    = 1'b0;
        mac_fe_pkt_len = '0;
        for (int p = 0; p < 8; p++) mac_fe_data[p*256 +: 256] = pat(p, 16'hEEEE);

        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_valid", 256'(fe_valid), 256'(0));
        check("rst_rdy", 256'(arb_mac_rdy), 256'(0));
        check("rst_sop", 256'(fe_sop), 256'(0));
        check("rst_eop", 256'(fe_eop), 256'(0));
        check("rst_port", 256'(fe_port), 256'(0));
        check("rst_len", 256'(fe_pkt_len), 256'(0));
        check("rst_cnt", 256'(pkt_cnt), 256'(0));
        check("rst_err", 256'(len_err), 256'(0));
        reset = 1'b1;
        step();

        // Single port 3, 64 bytes -> 2 beats; pointer moves to 4.
        set_len(3, 64);
        arb_valid = 8'h08;
        xfer(3, 64, 2, -1);
        arb_valid = '0;

        // Ports 0,2,7 from pointer 4: 7, 0, 2, 7, 0.
        set_len(0, 32); set_len(2, 32); set_len(7, 32);
        arb_valid = 8'h85;
        xfer(7, 32, 1, -1);
        xfer(0, 32, 1, -1);
        xfer(2, 32, 1, -1);
        xfer(7, 32, 1, -1);
        xfer(0, 32, 1, -1);
        arb_valid = '0;

        // Port 5, 100 bytes -> 4 beats, two-cycle stall before beat 2.
        set_len(5, 100);
        arb_valid = 8'h20;
        xfer(5, 100, 4, 1);
        arb_valid = '0;

        // Pointer 6, ports 1 and 6 requesting, 6 masked -> port 1.
        set_len(1, 32); set_len(6, 32);
        arb_valid = 8'h42;
        port_en   = 8'hBF;
        xfer(1, 32, 1, -1);
        arb_valid = '0;
        port_en   = 8'hFF;

        set_len(2, 0);
        arb_valid = 8'h04;
        xfer(2, 0, 1, -1);
        arb_valid = '0;
        check("err_len0", 256'(len_err), 256'(0));

        set_len(4, 1523);
        arb_valid = 8'h10;
        xfer(4, 1523, 48, -1);
        arb_valid = '0;
        check("err_1523", 256'(len_err), 256'(1));
        len_err_clr = 1'b1;
        step();
        len_err_clr = 1'b0;
        check("err_clr", 256'(len_err), 256'(0));

        // Clear asserted in the same cycle the error is latched: set wins.
        set_len(6, 4095);
        arb_valid   = 8'h40;
        len_err_clr = 1'b1;
        xfer(6, 4095, 128, -1);
        arb_valid = '0;
        check("err_setwins", 256'(len_err), 256'(1));
        len_err_clr = 1'b1;
        step();
        len_err_clr = 1'b0;
        check("err_clr2", 256'(len_err), 256'(0));

        set_len(7, 1522);
        arb_valid = 8'h80;
        xfer(7, 1522, 48, -1);
        arb_valid = '0;
        check("err_1522", 256'(len_err), 256'(0));

        // Reset during beat 2 of a 4-beat packet.
        set_len(5, 100);
        arb_valid = 8'h20;
        step();
        step();
        reset = 1'b0;
        #1;
        check("mid_busy", 256'(busy), 256'(0));
        check("mid_valid", 256'(fe_valid), 256'(0));
        check("mid_rdy", 256'(arb_mac_rdy), 256'(0));
        check("mid_sop", 256'(fe_sop), 256'(0));
        check("mid_port", 256'(fe_port), 256'(0));
        check("mid_len", 256'(fe_pkt_len), 256'(0));
        check("mid_cnt", 256'(pkt_cnt), 256'(0));
        check("mid_data", fe_data, 256'(0));
        step();
        reset     = 1'b1;
        exp_cnt   = 0;
        set_len(0, 100);
        arb_valid = 8'h21;
        xfer(0, 100, 4, -1);
        xfer(5, 100, 4, -1);
        arb_valid = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
